// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: request payload,
// arbiter FSM states and arbitration mode selectors.
package mem_arbiter_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int ADDR_WIDTH        = 32;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        addr;
    logic                         is_store;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational grant selection over the pending vector.
// Fixed mode: highest pending index wins.
// Round-robin mode: first pending index at or above ptr, wrapping to 0.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  pending,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                rr_mode,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_valid
);

  logic [ID_WIDTH-1:0] fixed_idx;
  logic [ID_WIDTH-1:0] wrap_idx;
  logic [ID_WIDTH-1:0] above_idx;
  logic                above_found;

  // Scan the pending vector: highest index, lowest index, lowest index >= ptr
  always_comb begin
    fixed_idx   = '0;
    wrap_idx    = '0;
    above_idx   = '0;
    above_found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pending[j]) fixed_idx = ID_WIDTH'(j);
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (pending[j]) begin
        wrap_idx = ID_WIDTH'(j);
        if (ID_WIDTH'(j) >= ptr) begin
          above_idx   = ID_WIDTH'(j);
          above_found = 1'b1;
        end
      end
    end
  end

  // Pick the result for the active mode
  always_comb begin
    grant_valid = |pending;
    if (rr_mode) grant_idx = above_found ? above_idx : wrap_idx;
    else         grant_idx = fixed_idx;
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-way cache-miss arbiter in front of a single main-memory port.
// Each requester holds one outstanding miss; one is granted, delayed by
// REQ_LATENCY cycles, issued to memory and its response routed back by id.
//
// Handshake: mm_req_valid_o is asserted in ISSUE and held with a stable
// mm_req_info_o until the cycle mm_req_ready_i is sampled high; the transfer
// happens on that edge. mm_rsp_valid_i is only honoured in RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int LINE_WIDTH  = DCACHE_LINE_WIDTH,
  parameter  int ARB_MODE    = ARB_MODE_FIXED,
  parameter  int REQ_LATENCY = 4,
  localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  memory_request_t [NUM_REQ-1:0]     req_info_i,
  output logic [NUM_REQ-1:0]                req_busy_o,
  output logic [NUM_REQ-1:0]                req_drop_o,
  output logic                              mm_req_valid_o,
  output memory_request_t                   mm_req_info_o,
  input  logic                              mm_req_ready_i,
  input  logic                              mm_rsp_valid_i,
  input  logic [LINE_WIDTH-1:0]             mm_rsp_data_i,
  output logic                              rsp_valid_o,
  output logic [ID_WIDTH-1:0]               rsp_id_o,
  output logic [LINE_WIDTH-1:0]             rsp_data_o,
  output arb_state_t                        dbg_state_o,
  output logic [ID_WIDTH-1:0]               dbg_rr_ptr_o
);

  localparam int CNT_W = (REQ_LATENCY > 1) ? $clog2(REQ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (REQ_LATENCY > 0) ? CNT_W'(REQ_LATENCY - 1) : '0;

  arb_state_t                    state_q, state_d;
  logic [NUM_REQ-1:0]            pending_q;
  memory_request_t [NUM_REQ-1:0] info_q;
  logic [NUM_REQ-1:0]            drop_q;
  logic [ID_WIDTH-1:0]           grant_q;
  memory_request_t               req_q;
  logic [ID_WIDTH-1:0]           ptr_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          rsp_valid_q;
  logic [ID_WIDTH-1:0]           rsp_id_q;
  logic [LINE_WIDTH-1:0]         rsp_data_q;

  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_valid;
  logic                grant_load;
  logic                rsp_fire;
  logic                cnt_dec;
  logic [NUM_REQ-1:0]  pend_clr, pend_set, pend_drop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .pending     (pending_q),
    .ptr         (ptr_q),
    .rr_mode     (ARB_MODE == ARB_MODE_RR),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          if (REQ_LATENCY == 0) state_d = ISSUE;
          else                  state_d = WAIT;
        end
      end
      WAIT:    if (cnt_q == '0)    state_d = ISSUE;
      ISSUE:   if (mm_req_ready_i) state_d = RESP;
      RESP:    if (mm_rsp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    mm_req_valid_o = (state_q == ISSUE);
    grant_load     = (state_q == IDLE) && grant_valid;
    rsp_fire       = (state_q == RESP) && mm_rsp_valid_i;
    cnt_dec        = (state_q == WAIT) && (cnt_q != '0);
  end

  // Per-requester set/clear/drop; a new pulse in the clearing cycle re-latches
  always_comb begin
    pend_clr  = '0;
    pend_set  = '0;
    pend_drop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_clr[i]  = rsp_fire && (grant_q == ID_WIDTH'(i));
      pend_set[i]  = req_valid_i[i] && (!pending_q[i] || pend_clr[i]);
      pend_drop[i] = req_valid_i[i] && pending_q[i] && !pend_clr[i];
    end
  end

  // Pending bits, captured payloads and registered drop pulses
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      info_q    <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= (pending_q & ~pend_clr) | pend_set;
      drop_q    <= pend_drop;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend_set[i]) info_q[i] <= req_info_i[i];
      end
    end
  end

  // Grant capture: index and payload frozen until the response returns
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      grant_q <= '0;
      req_q   <= '0;
      ptr_q   <= '0;
    end else if (grant_load) begin
      grant_q <= grant_idx;
      req_q   <= info_q[grant_idx];
      if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ptr_q <= '0;
      else                                     ptr_q <= grant_idx + ID_WIDTH'(1);
    end
  end

  // Latency counter: loaded at grant, counts down through WAIT
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n)        cnt_q <= '0;
    else if (grant_load) cnt_q <= CNT_LOAD;
    else if (cnt_dec)    cnt_q <= cnt_q - CNT_W'(1);
  end

  // Registered response to the requester; stores return zero data
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_id_q   <= grant_q;
        rsp_data_q <= req_q.is_store ? '0 : mm_rsp_data_i;
      end
    end
  end

  assign req_busy_o    = pending_q;
  assign req_drop_o    = drop_q;
  assign mm_req_info_o = req_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_data_o    = rsp_data_q;
  assign dbg_state_o   = state_q;
  assign dbg_rr_ptr_o  = ptr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-requester fixed-priority instance with no
// latency and a 4-requester round-robin instance with REQ_LATENCY=2.
// Expected responses (id, issued address, data) are queued in service order
// when requests are driven and compared when rsp_valid_o fires.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LW = DCACHE_LINE_WIDTH;
  localparam int W  = 2 + 32 + LW;

  logic clk_i = 1'b0;
  logic reset_n;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] e_a, e_b;

  // ---------------- DUT A: 2 requesters, fixed, latency 0 ----------------
  logic [1:0]            a_req_valid;
  memory_request_t [1:0] a_req_info;
  logic [1:0]            a_busy, a_drop;
  logic                  a_mm_valid, a_mm_ready, a_mm_rsp_valid;
  memory_request_t       a_mm_info;
  logic [LW-1:0]         a_mm_rsp_data, a_rsp_data;
  logic                  a_rsp_valid;
  logic [0:0]            a_rsp_id, a_dbg_ptr;
  arb_state_t            a_dbg_state;
  memory_request_t       a_shadow [2];
  int                    a_ready_dly = 0, a_rsp_dly = 0;

  mem_arbiter #(.NUM_REQ(2), .ARB_MODE(ARB_MODE_FIXED), .REQ_LATENCY(0)) u_dut_a (
    .clk_i(clk_i), .reset_n(reset_n),
    .req_valid_i(a_req_valid), .req_info_i(a_req_info),
    .req_busy_o(a_busy), .req_drop_o(a_drop),
    .mm_req_valid_o(a_mm_valid), .mm_req_info_o(a_mm_info), .mm_req_ready_i(a_mm_ready),
    .mm_rsp_valid_i(a_mm_rsp_valid), .mm_rsp_data_i(a_mm_rsp_data),
    .rsp_valid_o(a_rsp_valid), .rsp_id_o(a_rsp_id), .rsp_data_o(a_rsp_data),
    .dbg_state_o(a_dbg_state), .dbg_rr_ptr_o(a_dbg_ptr)
  );

  // ---------------- DUT B: 4 requesters, round-robin, latency 2 ----------------
  logic [3:0]            b_req_valid;
  memory_request_t [3:0] b_req_info;
  logic [3:0]            b_busy, b_drop;
  logic                  b_mm_valid, b_mm_ready, b_mm_rsp_valid;
  memory_request_t       b_mm_info;
  logic [LW-1:0]         b_mm_rsp_data, b_rsp_data;
  logic                  b_rsp_valid;
  logic [1:0]            b_rsp_id, b_dbg_ptr;
  arb_state_t            b_dbg_state;
  memory_request_t       b_shadow [4];
  int                    b_rsp_dly = 1;

  mem_arbiter #(.NUM_REQ(4), .ARB_MODE(ARB_MODE_RR), .REQ_LATENCY(2)) u_dut_b (
    .clk_i(clk_i), .reset_n(reset_n),
    .req_valid_i(b_req_valid), .req_info_i(b_req_info),
    .req_busy_o(b_busy), .req_drop_o(b_drop),
    .mm_req_valid_o(b_mm_valid), .mm_req_info_o(b_mm_info), .mm_req_ready_i(b_mm_ready),
    .mm_rsp_valid_i(b_mm_rsp_valid), .mm_rsp_data_i(b_mm_rsp_data),
    .rsp_valid_o(b_rsp_valid), .rsp_id_o(b_rsp_id), .rsp_data_o(b_rsp_data),
    .dbg_state_o(b_dbg_state), .dbg_rr_ptr_o(b_dbg_ptr)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory content model: line data is a fixed function of the address
  function automatic logic [LW-1:0] mem_data(input logic [31:0] addr);
    logic [LW-1:0] d;
    for (int k = 0; k < LW / 32; k++) d[k*32 +: 32] = addr ^ (32'h9e37_79b9 + 32'(k));
    return d;
  endfunction

  function automatic logic [W-1:0] make_exp(input int id, input memory_request_t r);
    logic [LW-1:0] d;
    d = r.is_store ? '0 : mem_data(r.addr);
    return {2'(id), r.addr, d};
  endfunction

  function automatic memory_request_t rand_req(input logic st);
    memory_request_t r;
    r.addr     = $urandom();
    r.is_store = st;
    r.data     = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r;
  endfunction

  task automatic a_set(input int id, input logic st);
    a_shadow[id]   = rand_req(st);
    a_req_info[id] = a_shadow[id];
  endtask

  task automatic b_set(input int id, input logic st);
    b_shadow[id]   = rand_req(st);
    b_req_info[id] = b_shadow[id];
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while ((exp_a_q.size() != 0 || a_dbg_state != IDLE || a_busy != '0) && n < 200) begin
      @(negedge clk_i); n++;
    end
    check(tag, 256'(n < 200), 256'(1));
    @(negedge clk_i);
  endtask

  task automatic wait_idle_b(input string tag);
    int n = 0;
    while ((exp_b_q.size() != 0 || b_dbg_state != IDLE || b_busy != '0) && n < 300) begin
      @(negedge clk_i); n++;
    end
    check(tag, 256'(n < 300), 256'(1));
    @(negedge clk_i);
  endtask

  // ---------------- memory models (drive on negedge) ----------------
  initial begin : mem_model_a
    memory_request_t cap;
    a_mm_ready = 1'b0; a_mm_rsp_valid = 1'b0; a_mm_rsp_data = '0;
    forever begin
      @(negedge clk_i);
      if (a_mm_valid) begin
        cap = a_mm_info;
        for (int k = 0; k < a_ready_dly; k++) begin
          @(negedge clk_i);
          check("a_hold_valid", 256'(a_mm_valid), 256'(1));
          check("a_hold_info", 256'(a_mm_info), 256'(cap));
        end
        if (exp_a_q.size() > 0) check("a_issue_addr", 256'(cap.addr), 256'(exp_a_q[0][LW +: 32]));
        a_mm_ready = 1'b1;
        @(negedge clk_i);
        a_mm_ready = 1'b0;
        for (int k = 0; k < a_rsp_dly; k++) @(negedge clk_i);
        a_mm_rsp_valid = 1'b1;
        a_mm_rsp_data  = mem_data(cap.addr);
        @(negedge clk_i);
        a_mm_rsp_valid = 1'b0;
      end
    end
  end

  initial begin : mem_model_b
    memory_request_t cap;
    b_mm_ready = 1'b0; b_mm_rsp_valid = 1'b0; b_mm_rsp_data = '0;
    forever begin
      @(negedge clk_i);
      if (b_mm_valid) begin
        cap = b_mm_info;
        if (exp_b_q.size() > 0) check("b_issue_addr", 256'(cap.addr), 256'(exp_b_q[0][LW +: 32]));
        b_mm_ready = 1'b1;
        @(negedge clk_i);
        b_mm_ready = 1'b0;
        for (int k = 0; k < b_rsp_dly; k++) @(negedge clk_i);
        b_mm_rsp_valid = 1'b1;
        b_mm_rsp_data  = mem_data(cap.addr);
        @(negedge clk_i);
        b_mm_rsp_valid = 1'b0;
      end
    end
  end

  // ---------------- scoreboards ----------------
  always @(negedge clk_i) begin
    if (a_rsp_valid) begin
      if (exp_a_q.size() == 0) check("a_unexpected_rsp", 256'(1), 256'(0));
      else begin
        e_a = exp_a_q.pop_front();
        check("a_rsp_id", 256'(a_rsp_id), 256'(e_a[W-1 -: 2]));
        check("a_rsp_data", 256'(a_rsp_data), 256'(e_a[LW-1:0]));
      end
    end
    if (b_rsp_valid) begin
      if (exp_b_q.size() == 0) check("b_unexpected_rsp", 256'(1), 256'(0));
      else begin
        e_b = exp_b_q.pop_front();
        check("b_rsp_id", 256'(b_rsp_id), 256'(e_b[W-1 -: 2]));
        check("b_rsp_data", 256'(b_rsp_data), 256'(e_b[LW-1:0]));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    reset_n = 1'b0;
    a_req_valid = '0; a_req_info = '0;
    b_req_valid = '0; b_req_info = '0;
    repeat (3) @(negedge clk_i);

    // reset state
    check("rst_a_busy",  256'(a_busy), 256'(0));
    check("rst_a_mmv",   256'(a_mm_valid), 256'(0));
    check("rst_a_rspv",  256'(a_rsp_valid), 256'(0));
    check("rst_a_state", 256'(a_dbg_state), 256'(IDLE));
    check("rst_b_ptr",   256'(b_dbg_ptr), 256'(0));
    reset_n = 1'b1;
    @(negedge clk_i);

    // single I$ load, latency 0: issue two cycles after the pulse, response two later
    a_set(0, 1'b0);
    exp_a_q.push_back(make_exp(0, a_shadow[0]));
    a_req_valid = 2'b01;
    @(negedge clk_i);
    a_req_valid = 2'b00; n = 1;
    check("a_busy_after_pulse", 256'(a_busy), 256'(2'b01));
    while (!a_mm_valid && n < 50) begin @(negedge clk_i); n++; end
    check("a_issue_latency", 256'(n), 256'(2));
    repeat (2) @(negedge clk_i);
    check("a_rsp_timing", 256'(a_rsp_valid), 256'(1));
    wait_idle_a("a_single_done");

    // simultaneous I$ and D$: D$ first, I$ issued right after with no idle gap
    a_set(0, 1'b0); a_set(1, 1'b0);
    exp_a_q.push_back(make_exp(1, a_shadow[1]));
    exp_a_q.push_back(make_exp(0, a_shadow[0]));
    a_req_valid = 2'b11;
    @(negedge clk_i);
    a_req_valid = 2'b00; n = 0;
    check("a_busy_both", 256'(a_busy), 256'(2'b11));
    while (!a_rsp_valid && n < 50) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    check("a_b2b_issue", 256'(a_mm_valid), 256'(1));
    wait_idle_a("a_both_done");

    // D$ pulses again while busy: one drop pulse, payload unchanged, one response
    a_set(1, 1'b0);
    exp_a_q.push_back(make_exp(1, a_shadow[1]));
    a_req_valid = 2'b10;
    @(negedge clk_i);
    check("a_no_drop_first", 256'(a_drop), 256'(0));
    a_req_info[1].addr = ~a_shadow[1].addr;
    @(negedge clk_i);
    a_req_valid = 2'b00;
    check("a_drop_pulse", 256'(a_drop), 256'(2'b10));
    @(negedge clk_i);
    check("a_drop_one_cycle", 256'(a_drop), 256'(0));
    wait_idle_a("a_drop_done");

    // memory holds ready low for 5 cycles; a store returns zero data
    a_ready_dly = 5;
    a_set(0, 1'b1);
    exp_a_q.push_back(make_exp(0, a_shadow[0]));
    a_req_valid = 2'b01;
    @(negedge clk_i);
    a_req_valid = 2'b00;
    wait_idle_a("a_store_done");
    a_ready_dly = 0;

    // new request in the very cycle the granted pending bit clears: latched, not dropped
    a_rsp_dly = 3;
    a_set(0, 1'b0);
    exp_a_q.push_back(make_exp(0, a_shadow[0]));
    a_req_valid = 2'b01;
    @(negedge clk_i);
    a_req_valid = 2'b00; n = 0;
    do begin @(negedge clk_i); #1; n++; end while (!a_mm_rsp_valid && n < 50);
    a_set(0, 1'b0);
    exp_a_q.push_back(make_exp(0, a_shadow[0]));
    a_req_valid = 2'b01;
    @(negedge clk_i);
    a_req_valid = 2'b00;
    check("a_setwins_nodrop", 256'(a_drop), 256'(0));
    check("a_setwins_busy", 256'(a_busy), 256'(2'b01));
    wait_idle_a("a_setwins_done");
    a_rsp_dly = 0;

    // round-robin: all four together -> 0,1,2,3, pointer back at 0, REQ_LATENCY=2
    for (int i = 0; i < 4; i++) begin
      b_set(i, 1'($urandom_range(0, 1)));
      exp_b_q.push_back(make_exp(i, b_shadow[i]));
    end
    b_req_valid = 4'hF;
    @(negedge clk_i);
    b_req_valid = 4'h0; n = 1;
    while (!b_mm_valid && n < 50) begin @(negedge clk_i); n++; end
    check("b_issue_latency", 256'(n), 256'(4));
    wait_idle_b("b_rr4_done");
    check("b_ptr_wrap", 256'(b_dbg_ptr), 256'(0));

    // pointer 0, pending {1,2} -> 1 then 2, pointer ends at 3
    b_set(1, 1'b0); b_set(2, 1'b0);
    exp_b_q.push_back(make_exp(1, b_shadow[1]));
    exp_b_q.push_back(make_exp(2, b_shadow[2]));
    b_req_valid = 4'b0110;
    @(negedge clk_i);
    b_req_valid = 4'h0;
    wait_idle_b("b_rr12_done");
    check("b_ptr_3", 256'(b_dbg_ptr), 256'(3));

    // pointer 3, pending {0,2} -> wraps to 0, then 2
    b_set(0, 1'b0); b_set(2, 1'b1);
    exp_b_q.push_back(make_exp(0, b_shadow[0]));
    exp_b_q.push_back(make_exp(2, b_shadow[2]));
    b_req_valid = 4'b0101;
    @(negedge clk_i);
    b_req_valid = 4'h0;
    wait_idle_b("b_rr_wrap_done");
    check("b_ptr_after_wrap", 256'(b_dbg_ptr), 256'(3));

    // reset during RESP: outputs drop at once, the late response is ignored
    a_rsp_dly = 8;
    a_set(0, 1'b0);
    a_req_valid = 2'b01;
    @(negedge clk_i);
    a_req_valid = 2'b00; n = 0;
    while (a_dbg_state != RESP && n < 50) begin @(negedge clk_i); n++; end
    check("a_reach_resp", 256'(a_dbg_state), 256'(RESP));
    #2 reset_n = 1'b0;
    #1;
    check("arst_a_busy",    256'(a_busy), 256'(0));
    check("arst_a_mmv",     256'(a_mm_valid), 256'(0));
    check("arst_a_mminfo",  256'(a_mm_info), 256'(0));
    check("arst_a_rspdata", 256'(a_rsp_data), 256'(0));
    check("arst_a_state",   256'(a_dbg_state), 256'(IDLE));
    check("arst_b_ptr",     256'(b_dbg_ptr), 256'(0));
    check("arst_b_rspdata", 256'(b_rsp_data), 256'(0));
    @(negedge clk_i); @(negedge clk_i);
    reset_n = 1'b1;
    repeat (15) @(negedge clk_i);
    check("a_post_rst_state", 256'(a_dbg_state), 256'(IDLE));
    check("a_post_rst_rspv",  256'(a_rsp_valid), 256'(0));
    a_rsp_dly = 0;

    // normal operation after reset
    a_set(1, 1'b0);
    exp_a_q.push_back(make_exp(1, a_shadow[1]));
    a_req_valid = 2'b10;
    @(negedge clk_i);
    a_req_valid = 2'b00;
    wait_idle_a("a_post_rst_done");

    check("a_queue_drained", 256'(exp_a_q.size()), 256'(0));
    check("b_queue_drained", 256'(exp_b_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
